// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command FIFO plus IDLE/EXEC/CAPT/RESP sequencer driving a registered ALU stage
// Optional statistics counters are built when the macro ALU_SEQ_STATS_EN is defined.
module alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_arg0,
  input  logic [WIDTH-1:0] i_cmd_arg1,
  input  logic [1:0]       i_cmd_oper,
  output logic [WIDTH-1:0] o_arg0,
  output logic [WIDTH-1:0] o_arg1,
  output logic [1:0]       o_oper,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [3:0]       i_alu_flag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic [3:0]       o_rsp_flag,
  output logic             o_busy,
  output logic [7:0]       o_err_cnt,
  output logic [7:0]       o_ovf_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 * WIDTH + 2;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop, capt, hs;
  logic [EW-1:0]   head;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign o_cmd_ready = !full;
  assign push        = i_cmd_valid && !full;
  assign head        = mem[rd_ptr];
  assign o_busy      = (state != S_IDLE) || !empty;

  // FIFO storage; entries need no reset because occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_cmd_arg0, i_cmd_arg1, i_cmd_oper};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state: RESP chains straight into EXEC when work is waiting
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!empty) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_CAPT;
      S_CAPT: state_nxt = S_RESP;
      S_RESP: if (i_rsp_ready) state_nxt = empty ? S_IDLE : S_EXEC;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: pop only from IDLE or on a response handshake, never when empty
  always_comb begin
    pop  = 1'b0;
    capt = 1'b0;
    hs   = 1'b0;
    case (state)
      S_IDLE: pop = !empty;
      S_CAPT: capt = 1'b1;
      S_RESP: begin
        hs  = i_rsp_ready;
        pop = i_rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // ALU drive and response registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_arg0       <= '0;
      o_arg1       <= '0;
      o_oper       <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_flag   <= '0;
    end else begin
      if (pop) {o_arg0, o_arg1, o_oper} <= head;
      if (capt) begin
        o_rsp_result <= i_alu_result;
        o_rsp_flag   <= i_alu_flag;
        o_rsp_valid  <= 1'b1;
      end else if (hs) begin
        o_rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating error/overflow counters, stepped once per accepted response
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err_cnt <= '0;
      o_ovf_cnt <= '0;
    end else if (hs) begin
      if (o_rsp_flag[0] && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
      if (o_rsp_flag[3] && (o_ovf_cnt != 8'hFF)) o_ovf_cnt <= o_ovf_cnt + 8'd1;
    end
  end
`else
  assign o_err_cnt = 8'd0;
  assign o_ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a registered ALU model attached
module tb_alu_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_arg0 = '0, cmd_arg1 = '0;
  logic [1:0]   cmd_oper = '0;
  logic [W-1:0] arg0, arg1;
  logic [1:0]   oper;
  logic [W-1:0] alu_result = '0;
  logic [3:0]   alu_flag = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flag;
  logic         busy;
  logic [7:0]   err_cnt, ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q[$];
  int mdl_err = 0, mdl_ovf = 0;
  bit stream_chk = 0;
  int last_hs = -1;
  logic         prev_valid = 0, prev_ready = 0;
  logic [W-1:0] prev_res, prev_a0, prev_a1;
  logic [3:0]   prev_flag;
  logic [1:0]   prev_op;

  alu_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_arg0(cmd_arg0), .i_cmd_arg1(cmd_arg1), .i_cmd_oper(cmd_oper),
    .o_arg0(arg0), .o_arg1(arg1), .o_oper(oper),
    .i_alu_result(alu_result), .i_alu_flag(alu_flag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_flag(rsp_flag),
    .o_busy(busy), .o_err_cnt(err_cnt), .o_ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference ALU: 00 sub, 01 add, 10 and, 11 unsupported (err). Returns {ovf,pos,neg,err,result}.
  function automatic logic [7:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    int sa, sb, r;
    logic err, ovf;
    logic [W-1:0] res;
    sa = $signed(a);
    sb = $signed(b);
    err = 1'b0;
    case (op)
      2'd0: r = sa - sb;
      2'd1: r = sa + sb;
      2'd2: r = sa & sb;
      default: begin r = 0; err = 1'b1; end
    endcase
    ovf = (r > 7) || (r < -8);
    res = r[W-1:0];
    return {ovf, (!err && ($signed(res) > 0)), ($signed(res) < 0), err, res};
  endfunction

  // Registered ALU stage attached to the sequencer drive
  always @(posedge clk) {alu_flag, alu_result} <= alu_ref(arg0, arg1, oper);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: predict on accepted commands, compare on response handshakes
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) exp_q.push_back(alu_ref(cmd_arg0, cmd_arg1, cmd_oper));
      if (prev_valid && !prev_ready) begin
        check("hold_valid", rsp_valid, 1'b1);
        check("hold_rsp", {rsp_flag, rsp_result}, {prev_flag, prev_res});
        check("hold_drive", {arg0, arg1, oper}, {prev_a0, prev_a1, prev_op});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected actual=%0h required=none", {rsp_flag, rsp_result});
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("rsp_data", {rsp_flag, rsp_result}, e);
          if (e[4]) mdl_err++;
          if (e[7]) mdl_ovf++;
        end
        if (stream_chk && last_hs >= 0) check("rsp_spacing", cyc - last_hs, 3);
        last_hs = cyc;
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_res   = rsp_result;
      prev_flag  = rsp_flag;
      prev_a0    = arg0;
      prev_a1    = arg1;
      prev_op    = oper;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int t;
    cmd_valid = 1'b1;
    cmd_arg0 = a;
    cmd_arg1 = b;
    cmd_oper = op;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout actual=ready_low required=ready_high");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rsp_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef ALU_SEQ_STATS_EN
    return (n > 255) ? 8'd255 : n[7:0];
`else
    return (n > -1) ? 8'd0 : 8'd0;
`endif
  endfunction

  initial begin
    logic [W-1:0] fa0[5], fa1[5];
    logic [1:0]   fop[5];
    int lat;

    // Reset state
    #2;
    check("rst_rsp", {rsp_valid, rsp_flag, rsp_result}, 0);
    check("rst_drive", {arg0, arg1, oper}, 0);
    check("rst_cnt", {err_cnt, ovf_cnt}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Single op: 3 - 1; response valid on the fourth edge counting the push edge
    push(4'd3, 4'd1, 2'd0);
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("single_latency", lat, 3);
    check("single_result", rsp_result, 4'd2);
    check("single_flag", rsp_flag, 4'b0100);
    rsp_ready = 1'b1;
    drain();

    // Fill under backpressure: 4 queued plus 1 in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fa0[i] = W'($urandom);
      fa1[i] = W'($urandom);
      fop[i] = 2'($urandom);
      push(fa0[i], fa1[i], fop[i]);
    end
    check("fill_ready_low", cmd_ready, 1'b0);
    check("fill_busy", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("stall_drive", {arg0, arg1, oper}, {fa0[0], fa1[0], fop[0]});
    check("stall_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_issue", {arg0, arg1, oper}, {fa0[1], fa1[1], fop[1]});
    check("release_ready", cmd_ready, 1'b1);
    drain();

    // Streaming with random operands: responses every 3 cycles
    last_hs = -1;
    stream_chk = 1'b1;
    for (int i = 0; i < 8; i++) push(W'($urandom), W'($urandom), 2'($urandom));
    drain();
    stream_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stats_err_a", err_cnt, exp_cnt(mdl_err));
    check("stats_ovf_a", ovf_cnt, exp_cnt(mdl_ovf));

    // Reset while in EXEC with two commands still queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'($urandom), W'($urandom), 2'($urandom));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rstn = 1'b0;
    exp_q.delete();
    mdl_err = 0;
    mdl_ovf = 0;
    #1;
    check("midrst_rsp", {rsp_valid, rsp_flag, rsp_result}, 0);
    check("midrst_drive", {arg0, arg1, oper}, 0);
    check("midrst_cnt", {err_cnt, ovf_cnt}, 0);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", cmd_ready, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_rsp", rsp_valid, 1'b0);

    // Error statistics: 300 unsupported-op responses
    for (int i = 0; i < 300; i++) push(W'($urandom), W'($urandom), 2'd3);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("stats_err_sat", err_cnt, exp_cnt(mdl_err));
    check("stats_ovf_b", ovf_cnt, exp_cnt(mdl_ovf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
